// File: rtl/prog_load_ctrl.sv
// Input-mode program loader: debounced entry/run buttons fill the
// instruction memory, trigger the hazard scan and gate the core.
module prog_load_ctrl #(
  parameter int DEPTH     = 8,
  parameter int AW        = 3,
  parameter int DB_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    input_val,
  input  logic          but_inp,
  input  logic          but_run,
  input  logic          hz_done,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic [AW:0]   load_count,
  output logic          hz_start,
  output logic          cpu_run,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    CHECK = 2'd1,
    READY = 2'd2,
    RUN   = 2'd3
  } st_t;

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [1:0] btn;
  logic [1:0] press;

  assign btn = {but_run, but_inp};

  // bit 0 = entry button, bit 1 = run button
  for (genvar i = 0; i < 2; i++) begin : g_db
    logic          s1;
    logic          s2;
    logic          lvl;
    logic          lvl_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1    <= 1'b0;
        s2    <= 1'b0;
        lvl   <= 1'b0;
        lvl_q <= 1'b0;
        cnt   <= '0;
      end else begin
        s1    <= btn[i];
        s2    <= s1;
        lvl_q <= lvl;
        if (s2 != lvl) begin
          if (cnt == CW'(DB_CYCLES - 1)) begin
            lvl <= ~lvl;
            cnt <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end else begin
          cnt <= '0;
        end
      end
    end

    assign press[i] = lvl & ~lvl_q;
  end

  st_t          state_q;
  st_t          state_d;
  logic         wr;
  logic         reload;
  logic [AW-1:0] ptr;

  always_comb begin
    state_d = state_q;
    wr      = 1'b0;
    reload  = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (press[0]) begin
          wr = 1'b1;
          if (ptr == AW'(DEPTH - 1)) state_d = CHECK;
        end
      end
      CHECK: begin
        // hz_done coinciding with the start pulse is stale
        if (hz_done && !hz_start) state_d = READY;
      end
      READY: begin
        if (press[1]) state_d = RUN;
      end
      RUN: begin
        if (press[1]) begin
          state_d = LOAD;
          reload  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      load_count <= '0;
      hz_start   <= 1'b0;
      cpu_run    <= 1'b0;
      ptr        <= '0;
    end else begin
      state_q  <= state_d;
      mem_we   <= wr;
      hz_start <= (state_q == LOAD) && (state_d == CHECK);
      cpu_run  <= (state_d == RUN);
      if (wr) begin
        mem_addr   <= ptr;
        mem_wdata  <= input_val;
        load_count <= load_count + (AW+1)'(1);
        ptr        <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
      end else if (reload) begin
        load_count <= '0;
        ptr        <= '0;
      end
    end
  end

  assign state = state_q;

endmodule
